pre_neuron_hist_ctrl: RTL
=========================

// Module: pre_neuron_hist_ctrl
// PURPOSE
//  Read-modify-write controller for the pre-synaptic spike-history SRAM. Accepts AER input-spike events,
//  reads the neuron's PRE_NEUR_SPIKE_CNT_WIDTH-bit history word and ORs in the one-hot bit of the current time step.
//  Writes the word back. Owns the time-step counter and the end-of-window clear sweep.
//  Sits between the input AER arbiter and the history SRAM; the history is later read by the STDP/weight-update stage.
// PARAMETERS
//  N_PRE                    256  number of pre-synaptic neurons (SRAM depth)
//  PRE_NEUR_SPIKE_CNT_WIDTH 8    history word width; must be >= TIME_STEP
//  TIME_STEP                8    time steps per reference window
//  ADDR_W                   clog2(N_PRE)  SRAM address width (localparam)
// PORTS
//  CLK               in   1        single clock; all logic on rising edge
//  RST               in   1        asynchronous reset, active-high
//  ev_valid          in   1        input spike event present
//  ev_addr           in   ADDR_W   pre-neuron index of the event
//  ev_ready          out  1        event accepted when ev_valid & ev_ready
//  ts_inc            in   1        one-cycle pulse: advance the time step
//  ref_req           in   1        one-cycle pulse: end of window, clear all histories
//  cur_ts            out  clog2(TIME_STEP)  current time step
//  sram_cs           out  1        SRAM chip select
//  sram_we           out  1        SRAM write enable (with sram_cs)
//  sram_addr         out  ADDR_W   SRAM address
//  sram_wdata        out  PRE_NEUR_SPIKE_CNT_WIDTH  write data
//  sram_rdata        in   PRE_NEUR_SPIKE_CNT_WIDTH  read data, valid 1 cycle after a read
//  busy              out  1        high in any state other than IDLE
//  clear_done        out  1        one-cycle pulse when the clear sweep finishes
// BEHAVIOUR
//  Reset values: all outputs 0, except ev_ready = 1 (IDLE); cur_ts = 0; pending flags cleared.
//  FSM states:
//   IDLE: ev_ready = 1.
//    Priority on a given cycle is ref > ts_inc > event.
//    ref_req, or a pending ref: go to CLEAR; ev_ready = 0 in that cycle.
//    Otherwise ts_inc, or a pending ts_inc: cur_ts advances; an event accepted in the same cycle uses the pre-increment cur_ts.
//    Event accept: latch addr and ts, drive a read (cs=1, we=0, addr=ev_addr), go to RD.
//   RD: ev_ready = 0.
//    Drive the write: cs=1, we=1, same addr, wdata = sram_rdata | (1 << latched_ts). Return to IDLE.
//    Latency is 2 cycles; throughput is one event per 2 cycles.
//    Single-port SRAM, so no read/write overlap and no RAW hazard exists.
//   CLEAR: ev_ready = 0.
//    Write 0 to addresses 0..N_PRE-1, one per cycle (cs=1, we=1).
//    After address N_PRE-1: pulse clear_done, set cur_ts = 0, go to IDLE. Sweep takes N_PRE cycles.
//  ts_inc or ref_req arriving outside IDLE is latched as pending and applied in the first IDLE cycle.
//   A ts_inc pending at ref is discarded (cur_ts forced to 0).
//   Multiple ts_inc pulses while busy collapse to one pending increment.
//  cur_ts at TIME_STEP-1 plus ts_inc wraps to 0.
//  Repeated spikes from the same neuron in one step are idempotent (OR). The history word is never shifted.
//  Bits at and above TIME_STEP in the word are written back unchanged.
//  Asynchronous RST at any point (including mid-RD or mid-CLEAR): return to IDLE, cur_ts = 0, pending cleared.
//   An aborted sweep leaves the SRAM partially cleared; software must issue a new ref_req.
//  sram_cs = 0 in every cycle where no access is listed above.
// STRUCTURE
//  Shared package snn_ff_pkg: state enum {IDLE,RD,CLEAR}, PRE_NEUR_SPIKE_CNT_WIDTH, TIME_STEP, clog2 function.
//  One sub-module: the existing pre_neuron update logic, instantiated for the OR-in computation
//   (neuron_event = RD state, time_ref_event = 0).
//  Controller FSM, address counter and cur_ts counter stay in this module.
// TESTING
//  1. After reset: event addr 5, cur_ts 0, rdata 0x00 -> read addr 5, then next cycle write addr 5 with 0x01.
//     ev_ready is low in the write cycle.
//  2. ts_inc x3, then event addr 5 with rdata 0x01 -> write data 0x09.
//     ts_inc and event in the same IDLE cycle -> the event uses the old ts.
//  3. cur_ts = 7, ts_inc -> cur_ts = 0. Event with rdata 0x80 at ts 7 -> write 0x80 (unchanged).
//  4. ref_req during RD -> write completes, then N_PRE consecutive zero-writes (addr 0..255), clear_done pulse at end, cur_ts = 0.
//     Events are held off throughout.
//  5. ref_req and ts_inc in the same IDLE cycle -> CLEAR is entered and cur_ts ends at 0.
//     Two ts_inc pulses during RD -> cur_ts advances by exactly 1.
//  6. RST asserted at sweep addr 100 -> all outputs are 0 immediately (async), ev_ready = 1.
//     A new ref_req restarts the sweep from addr 0.

Source files
------------

// File: rtl/snn_ff_pkg.sv
// Shared types and sizing helpers for the SNN feed-forward datapath blocks.
// Holds the controller state encoding and the default history/time-step geometry.
package snn_ff_pkg;

    localparam int PRE_NEUR_SPIKE_CNT_WIDTH = 8;
    localparam int TIME_STEP                = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        CLEAR = 2'd2
    } ctrl_state_t;

    // Never returns 0, so a value of 1 still gives a legal one-bit field.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pre_neuron_hist_ctrl_pre_neuron.sv
// Pre-synaptic history update: ORs the one-hot bit of the event's time step into
// the stored history word, or zeroes it on a reference-window event.
module pre_neuron
    import snn_ff_pkg::*;
#(
    parameter int W    = PRE_NEUR_SPIKE_CNT_WIDTH,
    parameter int TS_W = clog2(TIME_STEP)
)(
    input  logic            neuron_event,
    input  logic            time_ref_event,
    input  logic [TS_W-1:0] cur_ts,
    input  logic [W-1:0]    hist_in,
    output logic [W-1:0]    hist_out
);

    // NOTE: hist_out is assigned first on every path so this block stays purely
    // combinational; a branch that skipped it would infer a latch.
    always_comb begin
        hist_out = hist_in;
        if (time_ref_event) begin
            hist_out = '0;
        end else if (neuron_event) begin
            hist_out = hist_in | (W'(1) << cur_ts);
        end
    end

endmodule

// File: rtl/pre_neuron_hist_ctrl.sv
// Read-modify-write controller for the pre-synaptic spike-history SRAM.
// Owns the time-step counter, pending ts/ref flags and the end-of-window clear sweep.
module pre_neuron_hist_ctrl
    import snn_ff_pkg::*;
#(
    parameter int  N_PRE                    = 256,
    parameter int  PRE_NEUR_SPIKE_CNT_WIDTH = snn_ff_pkg::PRE_NEUR_SPIKE_CNT_WIDTH,
    parameter int  TIME_STEP                = snn_ff_pkg::TIME_STEP,
    localparam int ADDR_W                   = clog2(N_PRE),
    localparam int TS_W                     = clog2(TIME_STEP)
)(
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                ev_valid,
    input  logic [ADDR_W-1:0]                   ev_addr,
    output logic                                ev_ready,
    input  logic                                ts_inc,
    input  logic                                ref_req,
    output logic [TS_W-1:0]                     cur_ts,
    output logic                                sram_cs,
    output logic                                sram_we,
    output logic [ADDR_W-1:0]                   sram_addr,
    output logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_wdata,
    input  logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_rdata,
    output logic                                busy,
    output logic                                clear_done
);

    localparam int                W         = PRE_NEUR_SPIKE_CNT_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PRE - 1);
    localparam logic [TS_W-1:0]   LAST_TS   = TS_W'(TIME_STEP - 1);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] lat_addr;
    logic [TS_W-1:0]   lat_ts;
    logic              ts_pend;
    logic              ref_pend;
    logic              ref_go;
    logic              ts_go;
    logic              accept;
    logic              sweep_last;
    logic              rd_event;
    logic [W-1:0]      upd_word;

    // Priority inside IDLE is ref > ts_inc > event.
    assign ref_go     = (state == IDLE) && (ref_req || ref_pend);
    assign ts_go      = (state == IDLE) && !ref_go && (ts_inc || ts_pend);
    assign accept     = ev_valid && ev_ready;
    assign sweep_last = (state == CLEAR) && (clr_addr == LAST_ADDR);
    assign rd_event   = (state == RD);

    pre_neuron #(
        .W    (W),
        .TS_W (TS_W)
    ) u_pre_neuron (
        .neuron_event   (rd_event),
        .time_ref_event (1'b0),
        .cur_ts         (lat_ts),
        .hist_in        (sram_rdata),
        .hist_out       (upd_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ev_ready   = 1'b0;
        busy       = 1'b1;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        clear_done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (ref_go) begin
                    state_next = CLEAR;
                end else begin
                    ev_ready = 1'b1;
                    if (ev_valid) begin
                        sram_cs    = 1'b1;
                        sram_addr  = ev_addr;
                        state_next = RD;
                    end
                end
            end
            RD: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = lat_addr;
                sram_wdata = upd_word;
                state_next = IDLE;
            end
            CLEAR: begin
                sram_cs   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = clr_addr;
                if (sweep_last) begin
                    clear_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_addr <= '0;
            lat_addr <= '0;
            lat_ts   <= '0;
            cur_ts   <= '0;
            ts_pend  <= 1'b0;
            ref_pend <= 1'b0;
        end else begin
            if (accept) begin
                lat_addr <= ev_addr;
                lat_ts   <= cur_ts;
            end

            // Pending requests are consumed (or discarded under ref) in the first IDLE cycle.
            if (state == IDLE) begin
                ts_pend  <= 1'b0;
                ref_pend <= 1'b0;
            end else begin
                if (ts_inc) begin
                    ts_pend <= 1'b1;
                end
                if (ref_req) begin
                    ref_pend <= 1'b1;
                end
            end

            if (ts_go) begin
                cur_ts <= (cur_ts == LAST_TS) ? '0 : cur_ts + TS_W'(1);
            end else if (sweep_last) begin
                cur_ts <= '0;
            end

            if (state == CLEAR) begin
                clr_addr <= sweep_last ? '0 : clr_addr + ADDR_W'(1);
            end
        end
    end

endmodule
